// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion tracker behind the writeback arbiter.
//   Dispatch allocates one entry per instruction at the tail. Writebacks mark
//   entries done, possibly with an exception. The head retires at most once per
//   cycle. A faulting head raises a precise exception and flushes every entry.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   alloc_*_i / alloc_*_o    dispatch request, ready and granted index
//   wb_*_i                   completion from the writeback arbiter
//   commit_*_o               retiring head (fields zero when not retiring)
//   excpt_*_o, flush_o       precise exception report (fields zero when idle)
//   full_o, empty_o, count_o occupancy

package params_pkg;
  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int REGISTER_WIDTH  = 5;
  localparam int ADDR_WIDTH      = 32;
  typedef logic [3:0] excpt_cause_t;
endpackage

module reorder_buffer #(
  parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int REGISTER_WIDTH  = params_pkg::REGISTER_WIDTH,
  parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_valid_i,
  input  logic                         alloc_reg_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0]    alloc_wr_reg_i,
  input  logic [ADDR_WIDTH-1:0]        alloc_pc_i,
  output logic                         alloc_ready_o,
  output logic [ROB_ENTRY_WIDTH-1:0]   alloc_rob_idx_o,
  input  logic                         wb_completed_i,
  input  logic                         wb_excpt_i,
  input  logic [ROB_ENTRY_WIDTH-1:0]   wb_rob_idx_i,
  input  logic [ADDR_WIDTH-1:0]        wb_excpt_tval_i,
  input  params_pkg::excpt_cause_t     wb_excpt_cause_i,
  output logic                         commit_valid_o,
  output logic [ROB_ENTRY_WIDTH-1:0]   commit_rob_idx_o,
  output logic                         commit_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0]    commit_wr_reg_o,
  output logic [ADDR_WIDTH-1:0]        commit_pc_o,
  output logic                         excpt_valid_o,
  output logic [ADDR_WIDTH-1:0]        excpt_pc_o,
  output logic [ADDR_WIDTH-1:0]        excpt_tval_o,
  output params_pkg::excpt_cause_t     excpt_cause_o,
  output logic                         flush_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [ROB_ENTRY_WIDTH:0]     count_o
);

  localparam int ROB_ENTRIES = 2**ROB_ENTRY_WIDTH;
  localparam logic [ROB_ENTRY_WIDTH-1:0] IDX_ONE  = 1;
  localparam logic [ROB_ENTRY_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ROB_ENTRY_WIDTH:0]   CNT_FULL = ROB_ENTRIES;

  typedef struct packed {
    logic                     valid;
    logic                     done;
    logic                     excpt;
    logic                     reg_wr_en;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [ADDR_WIDTH-1:0]    pc;
    logic [ADDR_WIDTH-1:0]    tval;
    params_pkg::excpt_cause_t cause;
  } rob_entry_t;

  rob_entry_t [ROB_ENTRIES-1:0] rob_q, rob_d;
  logic [ROB_ENTRY_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ROB_ENTRY_WIDTH:0]     count_q, count_d;

  rob_entry_t head_e;
  logic       head_ready, commit, flush, alloc_fire, wb_any;

  assign head_e     = rob_q[head_q];
  assign head_ready = head_e.valid && head_e.done;
  assign commit     = head_ready && !head_e.excpt;
  assign flush      = head_ready && head_e.excpt;
  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  // Full is taken from the registered count: a commit in the same cycle does
  // not open a slot for an allocation until the next cycle.
  assign alloc_ready_o = !full_o && !flush;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign wb_any        = wb_completed_i || wb_excpt_i;

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < ROB_ENTRIES; i++) rob_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // The tail slot is never valid, so a writeback cannot collide with the
      // allocation write below.
      if (wb_any && rob_q[wb_rob_idx_i].valid) begin
        rob_d[wb_rob_idx_i].done  = 1'b1;
        rob_d[wb_rob_idx_i].excpt = wb_excpt_i;
        if (wb_excpt_i) begin
          rob_d[wb_rob_idx_i].tval  = wb_excpt_tval_i;
          rob_d[wb_rob_idx_i].cause = wb_excpt_cause_i;
        end
      end
      if (alloc_fire) begin
        rob_d[tail_q].valid     = 1'b1;
        rob_d[tail_q].done      = 1'b0;
        rob_d[tail_q].excpt     = 1'b0;
        rob_d[tail_q].reg_wr_en = alloc_reg_wr_en_i;
        rob_d[tail_q].wr_reg    = alloc_wr_reg_i;
        rob_d[tail_q].pc        = alloc_pc_i;
        rob_d[tail_q].tval      = '0;
        rob_d[tail_q].cause     = '0;
        tail_d = tail_q + IDX_ONE;
      end
      // Retirement clears the head last so it wins over a redundant writeback.
      if (commit) begin
        rob_d[head_q].valid = 1'b0;
        head_d = head_q + IDX_ONE;
      end
      if (alloc_fire && !commit)      count_d = count_q + CNT_ONE;
      else if (!alloc_fire && commit) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rob_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign alloc_rob_idx_o    = tail_q;
  assign count_o            = count_q;
  assign commit_valid_o     = commit;
  assign commit_rob_idx_o   = commit ? head_q           : '0;
  assign commit_reg_wr_en_o = commit ? head_e.reg_wr_en : 1'b0;
  assign commit_wr_reg_o    = commit ? head_e.wr_reg    : '0;
  assign commit_pc_o        = commit ? head_e.pc        : '0;
  assign excpt_valid_o      = flush;
  assign flush_o            = flush;
  assign excpt_pc_o         = flush ? head_e.pc    : '0;
  assign excpt_tval_o       = flush ? head_e.tval  : '0;
  assign excpt_cause_o      = flush ? head_e.cause : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int IW = 3;
  localparam int RW = 5;
  localparam int AW = 32;
  localparam int N  = 8;

  logic clk = 0, rst = 1;
  logic alloc_valid, alloc_reg_wr_en;
  logic [RW-1:0] alloc_wr_reg;
  logic [AW-1:0] alloc_pc;
  logic alloc_ready;
  logic [IW-1:0] alloc_rob_idx;
  logic wb_completed, wb_excpt;
  logic [IW-1:0] wb_rob_idx;
  logic [AW-1:0] wb_tval;
  logic [3:0] wb_cause;
  logic commit_valid, commit_reg_wr_en;
  logic [IW-1:0] commit_rob_idx;
  logic [RW-1:0] commit_wr_reg;
  logic [AW-1:0] commit_pc;
  logic excpt_valid, flush, full, empty;
  logic [AW-1:0] excpt_pc, excpt_tval;
  logic [3:0] excpt_cause;
  logic [IW:0] count;

  int tests = 0, fails = 0;
  bit started = 0;

  reorder_buffer #(.ROB_ENTRY_WIDTH(IW), .REGISTER_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_reg_wr_en_i(alloc_reg_wr_en),
    .alloc_wr_reg_i(alloc_wr_reg), .alloc_pc_i(alloc_pc),
    .alloc_ready_o(alloc_ready), .alloc_rob_idx_o(alloc_rob_idx),
    .wb_completed_i(wb_completed), .wb_excpt_i(wb_excpt), .wb_rob_idx_i(wb_rob_idx),
    .wb_excpt_tval_i(wb_tval), .wb_excpt_cause_i(wb_cause),
    .commit_valid_o(commit_valid), .commit_rob_idx_o(commit_rob_idx),
    .commit_reg_wr_en_o(commit_reg_wr_en), .commit_wr_reg_o(commit_wr_reg),
    .commit_pc_o(commit_pc),
    .excpt_valid_o(excpt_valid), .excpt_pc_o(excpt_pc), .excpt_tval_o(excpt_tval),
    .excpt_cause_o(excpt_cause), .flush_o(flush),
    .full_o(full), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: a queue of in-flight instructions, oldest first.
  typedef struct {
    int idx; bit wr; logic [RW-1:0] rg; logic [AW-1:0] pc;
    bit done; bit ex; logic [AW-1:0] tval; logic [3:0] cause;
  } ent_t;
  ent_t mq[$];
  int mtail = 0;

  function automatic bit m_head_done();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mtail = 0;
    end else begin
      bit hd, cm, ex, full_now;
      hd = m_head_done();
      cm = hd && !mq[0].ex;
      ex = hd && mq[0].ex;
      full_now = (mq.size() == N);
      if (ex) begin
        mq.delete();
        mtail = 0;
      end else begin
        if (wb_completed || wb_excpt)
          foreach (mq[i])
            if (mq[i].idx == int'(wb_rob_idx)) begin
              mq[i].done = 1;
              mq[i].ex = wb_excpt;
              if (wb_excpt) begin
                mq[i].tval = wb_tval;
                mq[i].cause = wb_cause;
              end
            end
        if (alloc_valid && !full_now) begin
          ent_t e;
          e.idx = mtail; e.wr = alloc_reg_wr_en; e.rg = alloc_wr_reg; e.pc = alloc_pc;
          e.done = 0; e.ex = 0; e.tval = '0; e.cause = '0;
          mq.push_back(e);
          mtail = (mtail + 1) % N;
        end
        if (cm) void'(mq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit hd, cm, ex;
      hd = m_head_done();
      cm = hd && !mq[0].ex;
      ex = hd && mq[0].ex;
      chk("m_commit_valid", commit_valid, cm);
      chk("m_commit_idx",   commit_rob_idx, cm ? mq[0].idx : 0);
      chk("m_commit_wr",    commit_reg_wr_en, cm ? mq[0].wr : 0);
      chk("m_commit_reg",   commit_wr_reg, cm ? mq[0].rg : 0);
      chk("m_commit_pc",    commit_pc, cm ? mq[0].pc : 0);
      chk("m_excpt_valid",  excpt_valid, ex);
      chk("m_flush",        flush, ex);
      chk("m_excpt_pc",     excpt_pc, ex ? mq[0].pc : 0);
      chk("m_excpt_tval",   excpt_tval, ex ? mq[0].tval : 0);
      chk("m_excpt_cause",  excpt_cause, ex ? mq[0].cause : 0);
      chk("m_count",        count, mq.size());
      chk("m_full",         full, mq.size() == N);
      chk("m_empty",        empty, mq.size() == 0);
      chk("m_alloc_ready",  alloc_ready, (mq.size() != N) && !ex);
      chk("m_alloc_idx",    alloc_rob_idx, mtail);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] pc, input bit wc, input bit we,
                       input int widx, input logic [AW-1:0] tval);
    alloc_valid = av; alloc_reg_wr_en = pc[2]; alloc_wr_reg = pc[6:2]; alloc_pc = pc;
    wb_completed = wc; wb_excpt = we; wb_rob_idx = widx[IW-1:0];
    wb_tval = tval; wb_cause = we ? 4'd2 : 4'd0;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, '0);
  endtask

  task automatic rst_pulse();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    idle();
    started = 1;
    cyc(); cyc();
    rst = 0;
    // Reset values
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_idx", alloc_rob_idx, 0);
    chk("rst_count", count, 0);

    // 1: reset mid-operation
    for (int i = 0; i < 3; i++) begin drive(1, 32'h40 + 4*i, 0, 0, 0, '0); cyc(); end
    idle();
    chk("t1_count_before", count, 3);
    #2 rst = 1;
    #1;
    chk("t1_count_rst", count, 0);
    chk("t1_empty_rst", empty, 1);
    chk("t1_idx_rst", alloc_rob_idx, 0);
    cyc();
    rst = 0;
    drive(0, '0, 1, 0, 1, '0); cyc();
    idle();
    chk("t1_stale_commit", commit_valid, 0);
    chk("t1_stale_empty", empty, 1);

    // 2: fill
    for (int i = 0; i < 9; i++) begin
      drive(1, 32'h80 + 4*i, 0, 0, 0, '0);
      chk("t2_ready", alloc_ready, i < 8);
      if (i < 8) chk("t2_idx", alloc_rob_idx, i);
      cyc();
    end
    idle();
    chk("t2_full", full, 1);
    chk("t2_count", count, 8);
    chk("t2_ready_full", alloc_ready, 0);
    rst_pulse();

    // 3: out-of-order completion
    for (int i = 0; i < 3; i++) begin drive(1, 32'h200 + 4*i, 0, 0, 0, '0); cyc(); end
    drive(0, '0, 1, 0, 2, '0); cyc();
    chk("t3_no_commit", commit_valid, 0);
    drive(0, '0, 1, 0, 0, '0); cyc();
    chk("t3_c0_valid", commit_valid, 1);
    chk("t3_c0_idx", commit_rob_idx, 0);
    chk("t3_c0_pc", commit_pc, 32'h200);
    drive(0, '0, 1, 0, 1, '0); cyc();
    idle();
    chk("t3_c1_idx", commit_rob_idx, 1);
    chk("t3_c1_reg", commit_wr_reg, 5'd1);
    cyc();
    chk("t3_c2_idx", commit_rob_idx, 2);
    chk("t3_c2_valid", commit_valid, 1);
    cyc();
    chk("t3_empty", empty, 1);
    rst_pulse();

    // 4: precise exception
    for (int i = 0; i < 3; i++) begin drive(1, 32'h100 + 4*i, 0, 0, 0, '0); cyc(); end
    drive(0, '0, 1, 0, 0, '0); cyc();
    chk("t4_c0_idx", commit_rob_idx, 0);
    drive(0, '0, 1, 0, 2, '0); cyc();
    drive(0, '0, 0, 1, 1, 32'hDEAD); cyc();
    idle();
    chk("t4_excpt", excpt_valid, 1);
    chk("t4_flush", flush, 1);
    chk("t4_pc", excpt_pc, 32'h104);
    chk("t4_tval", excpt_tval, 32'hDEAD);
    chk("t4_cause", excpt_cause, 4'd2);
    chk("t4_no_commit", commit_valid, 0);
    chk("t4_ready", alloc_ready, 0);
    drive(1, 32'h300, 0, 0, 0, '0); cyc();
    idle();
    chk("t4_empty_after", empty, 1);
    chk("t4_idx_after", alloc_rob_idx, 0);
    chk("t4_excpt_after", excpt_valid, 0);

    // 5: wrap-around with steady occupancy of 4
    for (int i = 0; i < 4; i++) begin drive(1, 32'h400 + 4*i, 0, 0, 0, '0); cyc(); end
    drive(0, '0, 1, 0, 0, '0); cyc();
    for (int j = 0; j < 12; j++) begin
      drive(1, 32'h410 + 4*j, 1, 0, (j + 1) % N, '0);
      chk("t5_commit", commit_valid, 1);
      chk("t5_commit_idx", commit_rob_idx, j % N);
      chk("t5_grant_idx", alloc_rob_idx, (4 + j) % N);
      chk("t5_count", count, 4);
      cyc();
    end
    idle();
    rst_pulse();

    // 6: stale writeback to a free index
    drive(0, '0, 1, 0, 5, '0); cyc();
    idle();
    chk("t6_no_commit", commit_valid, 0);
    chk("t6_empty", empty, 1);
    for (int i = 0; i < 6; i++) begin drive(1, 32'h500 + 4*i, 0, 0, 0, '0); cyc(); end
    drive(0, '0, 1, 0, 0, '0); cyc();
    idle();
    chk("t6_c0", commit_rob_idx, 0);
    cyc();
    chk("t6_idx5_not_done", commit_valid, 0);
    cyc();

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
